cnn_conv_engine: RTL and testbench
==================================

CNN_CONV_ENGINE -- requirements
Module: cnn_conv_engine

Interface
REQ-001 Parameter IMG_W, 8, input frame width in pixels (>= K).
REQ-002 Parameter IMG_H, 8, input frame height in pixels (>= K).
REQ-003 Parameter K, 3, square kernel side (>= 1).
REQ-004 Parameter DATA_W, 16, signed pixel/weight width.
REQ-005 Parameter ACC_W, 2*DATA_W+$clog2(K*K)+1, signed accumulator/output width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  begin frame load; sampled only in IDLE.
REQ-009 w_wr, w_addr, w_data  in  1/$clog2(K*K)/DATA_W  kernel weight write port, row-major.
REQ-010 pix_valid, pix_data  in  1/DATA_W  pixel stream, raster order; pix_ready out 1.
REQ-011 out_valid  out  1; out_data  out  ACC_W; out_ready  in  1  feature-map stream.
REQ-012 value  out  ACC_W  running maximum of emitted outputs (prediction).
REQ-013 busy  out  1  high in any state except IDLE; done  out  1  one-cycle frame-complete pulse.

Function
REQ-014 FSM states IDLE, LOAD, MAC, EMIT, FIN; IDLE->LOAD on start, LOAD->MAC after IMG_W*IMG_H pixels accepted, MAC->EMIT after K*K MAC cycles, EMIT->MAC on out handshake if positions remain, else EMIT->FIN, FIN->IDLE after one cycle.
REQ-015 pix_ready high only in LOAD; pixel stored on pix_valid&&pix_ready; pixels outside LOAD ignored.
REQ-016 Weight writes accepted only in IDLE; writes in other states ignored; weights retained across frames.
REQ-017 Output positions stride 1, no padding: (IMG_W-K+1)*(IMG_H-K+1) outputs, raster order.
REQ-018 Each output = signed sum of pixel*weight over the KxK window, one product per cycle, full-precision in ACC_W, no saturation.
REQ-019 First out_valid asserted exactly K*K+1 cycles after the last pixel handshake; subsequent outputs K*K+1 cycles after the previous out handshake.
REQ-020 While out_valid && !out_ready, out_data and out_valid hold stable; no MAC progress.
REQ-021 value cleared to most-negative ACC_W value on start; updated on each out handshake to max(value, out_data); held after done until next start.
REQ-022 done pulses high for exactly one cycle in FIN, coincident with busy still high; busy low the following cycle.
REQ-023 start while busy ignored; start and w_wr in the same IDLE cycle: weight write completes, FSM enters LOAD.
REQ-024 K=IMG_W=IMG_H yields exactly one output.

Reset
REQ-025 rst low asynchronously forces IDLE; out_valid, out_data, pix_ready, busy, done = 0; value = most-negative ACC_W value; position/MAC counters = 0.
REQ-026 Reset mid-frame aborts the frame with no done pulse; weight memory contents are undefined after reset and must be rewritten.
REQ-027 Reset deassertion is synchronised internally; first start is honoured no earlier than the second clk edge after release.

Configuration
REQ-028 Macro CNN_CONV_RELU_EN defined: out_data = max(sum, 0) before output and before the value update.
REQ-029 CNN_CONV_RELU_EN undefined: out_data = raw signed sum; no clamping logic synthesised.

Verification
REQ-030 Defaults with IMG_W=IMG_H=4, K=3; all weights 1; 16 pixels of 1; out_ready=1 -> 4 outputs of 9, first 10 cycles after last pixel, value=9, one done pulse.
REQ-031 Weight centre=-1, others 0; pixels 1 -> outputs -1, value=-1 without macro; outputs 0, value=0 with CNN_CONV_RELU_EN.
REQ-032 Pixels 0..15 raster, weights all 1, out_ready toggled 1/0 each cycle -> outputs 45,54,81,90 in order, out_data stable while stalled, value=90.
REQ-033 rst pulled low during MAC of output 2 -> busy/out_valid drop immediately, no done; rewrite weights, new frame completes correctly.
REQ-034 start and pixels during MAC, w_wr during LOAD -> all ignored; results identical to REQ-030.

Source files
------------

// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: buffers one frame, then emits a KxK stride-1 valid convolution, one MAC per cycle.
// Build option CNN_CONV_RELU_EN clamps each output at zero before emission and max tracking.

module cnn_conv_engine #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K*K) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     w_wr,
  input  logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0] w_addr,
  input  logic signed [DATA_W-1:0]                 w_data,
  input  logic                                     pix_valid,
  input  logic signed [DATA_W-1:0]                 pix_data,
  output logic                                     pix_ready,
  output logic                                     out_valid,
  output logic signed [ACC_W-1:0]                  out_data,
  input  logic                                     out_ready,
  output logic signed [ACC_W-1:0]                  value,
  output logic                                     busy,
  output logic                                     done,
  output logic [2:0]                               dbg_state
);

  localparam int KK    = K*K;
  localparam int N_PIX = IMG_W*IMG_H;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int WA_W  = (KK > 1) ? $clog2(KK) : 1;
  localparam int MC_W  = $clog2(KK + 1);
  localparam int PA_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int KC_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                   state;
  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic [PA_W-1:0]          pix_cnt;
  logic [MC_W-1:0]          mac_cnt;
  logic [KC_W-1:0]          kr, kc;
  logic [OX_W-1:0]          ox;
  logic [OY_W-1:0]          oy;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] w_mem   [KK];
  logic signed [DATA_W-1:0] pix_mem [N_PIX];

  logic [PA_W-1:0]            pix_idx;
  logic [WA_W-1:0]            w_idx;
  logic signed [DATA_W-1:0]   pix_sel, w_sel;
  logic signed [2*DATA_W-1:0] pix_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, result;
  logic                       last_pos;

  // Assertion is immediate; release is re-timed through two flops before the FSM sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n     = rst_sync[1];
  assign dbg_state = state;

  // Storage carries no reset: weights must be rewritten after any reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && w_wr && 32'(w_addr) < KK) w_mem[w_addr] <= w_data;
    if (pix_valid && pix_ready) pix_mem[pix_cnt] <= pix_data;
  end

  always_comb begin
    pix_idx  = PA_W'((32'(oy) + 32'(kr)) * IMG_W + 32'(ox) + 32'(kc));
    w_idx    = WA_W'(mac_cnt);
    pix_sel  = pix_mem[pix_idx];
    w_sel    = w_mem[w_idx];
    pix_ext  = {{DATA_W{pix_sel[DATA_W-1]}}, pix_sel};
    w_ext    = {{DATA_W{w_sel[DATA_W-1]}}, w_sel};
    prod     = pix_ext * w_ext;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`ifdef CNN_CONV_RELU_EN
    result   = acc[ACC_W-1] ? '0 : acc;
`else
    result   = acc;
`endif
    last_pos = (ox == OX_W'(OUT_W-1)) && (oy == OY_W'(OUT_H-1));
  end

  // Both streams: a beat transfers on the rising edge where valid && ready; the producer holds
  // valid and data stable until that edge, and the consumer may drive ready freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pix_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      value     <= MOST_NEG;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_cnt   <= '0;
      mac_cnt   <= '0;
      kr        <= '0;
      kc        <= '0;
      ox        <= '0;
      oy        <= '0;
      acc       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            pix_ready <= 1'b1;
            pix_cnt   <= '0;
            value     <= MOST_NEG;
          end
        end
        S_LOAD: begin
          if (pix_valid) begin
            if (pix_cnt == PA_W'(N_PIX-1)) begin
              state     <= S_MAC;
              pix_ready <= 1'b0;
              mac_cnt   <= '0;
              kr        <= '0;
              kc        <= '0;
              ox        <= '0;
              oy        <= '0;
              acc       <= '0;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        // KK product cycles, then one cycle to register the finished sum onto out_data.
        S_MAC: begin
          if (mac_cnt == MC_W'(KK)) begin
            state     <= S_EMIT;
            out_valid <= 1'b1;
            out_data  <= result;
          end else begin
            acc     <= acc + prod_ext;
            mac_cnt <= mac_cnt + 1'b1;
            if (kc == KC_W'(K-1)) begin
              kc <= '0;
              kr <= (kr == KC_W'(K-1)) ? '0 : kr + 1'b1;
            end else begin
              kc <= kc + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_data > value) value <= out_data;
            mac_cnt <= '0;
            kr      <= '0;
            kc      <= '0;
            acc     <= '0;
            if (last_pos) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_MAC;
              if (ox == OX_W'(OUT_W-1)) begin
                ox <= '0;
                oy <= oy + 1'b1;
              end else begin
                ox <= ox + 1'b1;
              end
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Bench for cnn_conv_engine: 4x4 frame / 3x3 kernel instance plus a 3x3 / 3x3 single-window instance.
// Expected outputs come from a direct nested-loop convolution model; CNN_CONV_RELU_EN is honoured.

module tb_cnn_conv_engine;

  localparam int IMG  = 4;
  localparam int K    = 3;
  localparam int KK   = K*K;
  localparam int NPIX = IMG*IMG;
  localparam int OW   = IMG - K + 1;
  localparam int NOUT = OW*OW;
  localparam int DW   = 16;
  localparam int AW   = 2*DW + $clog2(KK) + 1;
  localparam int WA   = $clog2(KK);
  localparam logic [AW-1:0] MOST_NEG = {1'b1, {(AW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst;
  logic          start, w_wr, pix_valid, pix_ready, out_valid, out_ready, busy, done;
  logic [WA-1:0] w_addr;
  logic [DW-1:0] w_data, pix_data;
  logic [AW-1:0] out_data, value;
  logic [2:0]    dbg_state;

  logic          s_start, s_w_wr, s_pix_valid, s_pix_ready, s_out_valid, s_out_ready, s_busy, s_done;
  logic [WA-1:0] s_w_addr;
  logic [DW-1:0] s_w_data, s_pix_data;
  logic [AW-1:0] s_out_data, s_value;
  logic [2:0]    s_dbg_state;

  int total = 0;
  int bad   = 0;
  int cur_p [NPIX];
  int cur_w [KK];

  always #5 clk = ~clk;

  cnn_conv_engine #(.IMG_W(IMG), .IMG_H(IMG), .K(K), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .value(value), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  cnn_conv_engine #(.IMG_W(K), .IMG_H(K), .K(K), .DATA_W(DW)) dut_single (
    .clk(clk), .rst(rst), .start(s_start), .w_wr(s_w_wr), .w_addr(s_w_addr), .w_data(s_w_data),
    .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_ready(s_pix_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .value(s_value), .busy(s_busy), .done(s_done), .dbg_state(s_dbg_state)
  );

  function automatic longint act(input longint s);
`ifdef CNN_CONV_RELU_EN
    return (s < 0) ? 64'sd0 : s;
`else
    return s;
`endif
  endfunction

  // Runs one frame on the 4x4 instance. mode: 0 ready always, 1 toggling, 2 random.
  // junk drives ignored traffic; abort_after>0 pulls reset while computing output abort_after+1.
  task automatic run_frame(input int mode, input bit junk, input bit write_w,
                           input bit start_with_w, input int abort_after);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] held, e;
    longint        s, vmax;
    int            i, cyc, outs;
    bit            waiting, hs, rdy;

    vmax = -(64'sd1 <<< (AW-1));
    for (int oy = 0; oy < OW; oy++)
      for (int ox = 0; ox < OW; ox++) begin
        s = 0;
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            s += longint'(cur_p[(oy+ky)*IMG + ox + kx]) * longint'(cur_w[ky*K + kx]);
        s = act(s);
        exp_q.push_back(AW'(s));
        if (s > vmax) vmax = s;
      end

    if (write_w) begin
      for (int k = 0; k < KK; k++) begin
        w_wr   = 1'b1;
        w_addr = WA'(k);
        w_data = DW'(cur_w[k]);
        start  = start_with_w && (k == KK-1);
        @(negedge clk);
      end
      w_wr = 1'b0;
    end
    if (!(write_w && start_with_w)) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_entry: got busy=%0b pix_ready=%0b want 1 1", busy, pix_ready);
    end
    total++;
    if (value !== MOST_NEG) begin
      bad++;
      $display("FAIL value_cleared: got %0d want %0d", $signed(value), $signed(MOST_NEG));
    end

    i = 0;
    cyc = 0;
    while (i < NPIX && cyc < 500) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data  = pix_valid ? DW'(cur_p[i]) : DW'($urandom);
      if (junk) begin
        w_wr   = $urandom_range(0, 1);
        w_addr = WA'($urandom_range(0, KK-1));
        w_data = DW'($urandom);
      end
      hs = pix_valid && pix_ready;
      @(negedge clk);
      if (hs) i++;
      cyc++;
    end
    pix_valid = 1'b0;
    w_wr = 1'b0;
    total++;
    if (i != NPIX) begin
      bad++;
      $display("FAIL pixel_timeout: got %0d pixels want %0d", i, NPIX);
    end

    cyc = 0;
    outs = 0;
    waiting = 1'b1;
    rdy = 1'b1;
    for (int t = 0; t < 3000 && outs < NOUT; t++) begin
      if (abort_after > 0 && outs == abort_after && !out_valid && cyc == 4) begin
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, done, pix_ready} !== 4'b0) begin
          bad++;
          $display("FAIL abort_async: got busy,valid,done,ready=%b want 0000",
                   {busy, out_valid, done, pix_ready});
        end
        out_ready = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          total++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet: got done=%0b busy=%0b want 0 0", done, busy);
          end
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = $urandom_range(0, 1);
      endcase
      out_ready = rdy;
      if (junk && !out_valid) begin
        start = 1'b1;
        pix_valid = 1'b1;
        pix_data = DW'($urandom);
      end else begin
        start = 1'b0;
        pix_valid = 1'b0;
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL early_done: got %0b want 0 before output %0d", done, outs);
      end
      if (out_valid) begin
        total++;
        if (waiting) begin
          if (cyc != KK+1) begin
            bad++;
            $display("FAIL latency[%0d]: got %0d cycles want %0d", outs, cyc, KK+1);
          end
          waiting = 1'b0;
          held = out_data;
        end else if (out_data !== held) begin
          bad++;
          $display("FAIL stall_hold[%0d]: got %0d want %0d", outs, $signed(out_data), $signed(held));
        end
      end else if (!waiting) begin
        total++;
        bad++;
        $display("FAIL valid_dropped[%0d]: got out_valid=0 want 1", outs);
      end
      hs = out_valid && out_ready;
      if (hs) begin
        e = exp_q.pop_front();
        total++;
        if (out_data !== e) begin
          bad++;
          $display("FAIL out_data[%0d]: got %0d want %0d", outs, $signed(out_data), $signed(e));
        end
        outs++;
        waiting = 1'b1;
      end
      @(negedge clk);
      if (hs) cyc = 0;
      else    cyc++;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    total++;
    if (outs != NOUT) begin
      bad++;
      $display("FAIL output_timeout: got %0d outputs want %0d", outs, NOUT);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: got done=%0b busy=%0b want 1 1", done, busy);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_end: got done=%0b busy=%0b want 0 0", done, busy);
    end
    total++;
    if (value !== AW'(vmax)) begin
      bad++;
      $display("FAIL value: got %0d want %0d", $signed(value), vmax);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, out_valid, pix_ready} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy,done,valid,ready=%b want 0000", {busy, done, out_valid, pix_ready});
    end
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL reset_out_data: got %0d want 0", $signed(out_data));
    end
    total++;
    if (value !== MOST_NEG) begin
      bad++;
      $display("FAIL reset_value: got %0d want %0d", $signed(value), $signed(MOST_NEG));
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_start: got busy=%0b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got busy=%0b pix_ready=%0b want 0 0", busy, pix_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_sync();
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_sync_early_start: got busy=%0b want 0", busy);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    foreach (cur_p[i]) cur_p[i] = 1;
    foreach (cur_w[i]) cur_w[i] = 1;
    run_frame(0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_centre_weight();
    foreach (cur_p[i]) cur_p[i] = 1;
    foreach (cur_w[i]) cur_w[i] = 0;
    cur_w[KK/2] = -1;
    run_frame(0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ramp_stall();
    foreach (cur_p[i]) cur_p[i] = i;
    foreach (cur_w[i]) cur_w[i] = 1;
    run_frame(1, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ignored_inputs();
    foreach (cur_p[i]) cur_p[i] = 1;
    foreach (cur_w[i]) cur_w[i] = 1;
    run_frame(0, 1'b1, 1'b1, 1'b0, 0);
    foreach (cur_p[i]) cur_p[i] = $signed(DW'($urandom));
    run_frame(2, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_start_with_weight();
    foreach (cur_p[i]) cur_p[i] = $signed(DW'($urandom));
    foreach (cur_w[i]) cur_w[i] = $signed(DW'($urandom));
    run_frame(2, 1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_reset_mid_frame();
    foreach (cur_p[i]) cur_p[i] = i - 7;
    foreach (cur_w[i]) cur_w[i] = 3 - i;
    run_frame(0, 1'b0, 1'b1, 1'b0, 1);
    run_frame(0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_extremes();
    foreach (cur_p[i]) cur_p[i] = -32768;
    foreach (cur_w[i]) cur_w[i] = -32768;
    run_frame(0, 1'b0, 1'b1, 1'b0, 0);
    foreach (cur_p[i]) cur_p[i] = (i % 2) ? 32767 : -32768;
    foreach (cur_w[i]) cur_w[i] = (i % 3) ? -32768 : 32767;
    run_frame(2, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      foreach (cur_p[i]) cur_p[i] = $signed(DW'($urandom));
      foreach (cur_w[i]) cur_w[i] = $signed(DW'($urandom));
      run_frame(2, f[0], 1'b1, f[1], 0);
    end
  endtask

  task automatic test_single_window();
    int     p [KK];
    int     w [KK];
    longint s;
    int     cyc;
    s = 0;
    for (int k = 0; k < KK; k++) begin
      p[k] = $signed(DW'($urandom));
      w[k] = $signed(DW'($urandom));
      s += longint'(p[k]) * longint'(w[k]);
    end
    s = act(s);
    for (int k = 0; k < KK; k++) begin
      s_w_wr = 1'b1;
      s_w_addr = WA'(k);
      s_w_data = DW'(w[k]);
      @(negedge clk);
    end
    s_w_wr = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < KK; k++) begin
      s_pix_valid = 1'b1;
      s_pix_data = DW'(p[k]);
      @(negedge clk);
    end
    s_pix_valid = 1'b0;
    s_out_ready = 1'b1;
    cyc = 0;
    while (!s_out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != KK+1) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles want %0d", cyc, KK+1);
    end
    total++;
    if (s_out_data !== AW'(s)) begin
      bad++;
      $display("FAIL single_out_data: got %0d want %0d", $signed(s_out_data), s);
    end
    @(negedge clk);
    total++;
    if (s_done !== 1'b1 || s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_done: got done=%0b valid=%0b want 1 0", s_done, s_out_valid);
    end
    @(negedge clk);
    s_out_ready = 1'b0;
    total++;
    if (s_busy !== 1'b0 || s_value !== AW'(s)) begin
      bad++;
      $display("FAIL single_end: got busy=%0b value=%0d want 0 %0d", s_busy, $signed(s_value), s);
    end
  endtask

  initial begin
    start = 1'b0; w_wr = 1'b0; w_addr = '0; w_data = '0;
    pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
    s_start = 1'b0; s_w_wr = 1'b0; s_w_addr = '0; s_w_data = '0;
    s_pix_valid = 1'b0; s_pix_data = '0; s_out_ready = 1'b0;
    test_reset();
    test_reset_sync();
    test_all_ones();
    test_centre_weight();
    test_ramp_stall();
    test_ignored_inputs();
    test_start_with_weight();
    test_reset_mid_frame();
    test_extremes();
    test_random();
    test_single_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
